// File: rtl/seg7_scan_to_bcd_if.sv
// Display-scan bus: multiplexed segment/anode lines in, recovered BCD digits and status out.
interface seg7_scan_to_bcd_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   an_n;
   logic [4*NUM_DIGITS-1:0] bcd_out;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    frame_valid;
   logic                    frame_err;
   logic                    decode_err;

   modport master (
      output seg_n, an_n,
      input  bcd_out, digit_valid, frame_valid, frame_err, decode_err
   );

   modport slave (
      input  seg_n, an_n,
      output bcd_out, digit_valid, frame_valid, frame_err, decode_err
   );
endinterface

// File: rtl/seg7_scan_to_bcd.sv
// Recovers per-position BCD digits from scanned active-low 7-segment drive lines, accepting a
// digit only after it has been sampled unchanged for STABLE_CYCLES consecutive edges.
module seg7_scan_to_bcd #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic               i_clk,
   input logic               i_rst_n,
   seg7_scan_to_bcd_if.slave io_bus
);
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {StIdle, StDwell, StHeld} state_e;

   state_e                  r_state, w_state_d;
   logic [7:0]              r_count, w_count_d, w_inc;
   logic [6:0]              r_s_seg, r_p_seg;
   logic [NUM_DIGITS-1:0]   r_s_an, r_p_an;
   logic [4*NUM_DIGITS-1:0] r_bcd, w_bcd_d;
   logic [NUM_DIGITS-1:0]   r_dv, w_dv_d, r_mask, w_mask_d, w_new;
   logic                    r_err, w_err_d, r_fv, w_fv_d, r_fe, w_fe_d, r_de, w_de_d;
   logic                    w_act, w_same, w_cap, w_bad;
   logic [3:0]              w_hot_cnt, w_code;
   logic [IdxW-1:0]         w_idx;

   function automatic logic [3:0] f_decode(input logic [6:0] seg);
      case (seg)
         7'h40:   f_decode = 4'd0;
         7'h79:   f_decode = 4'd1;
         7'h24:   f_decode = 4'd2;
         7'h30:   f_decode = 4'd3;
         7'h19:   f_decode = 4'd4;
         7'h12:   f_decode = 4'd5;
         7'h02:   f_decode = 4'd6;
         7'h78:   f_decode = 4'd7;
         7'h00:   f_decode = 4'd8;
         7'h10:   f_decode = 4'd9;
         7'h7F:   f_decode = 4'hF;
         default: f_decode = 4'hE;
      endcase
   endfunction

   // Active only when exactly one anode is driven low.
   always_comb begin
      w_hot_cnt = 4'd0;
      w_idx     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!r_s_an[i]) begin
            w_hot_cnt = w_hot_cnt + 4'd1;
            w_idx     = i[IdxW-1:0];
         end
      end
      w_act  = (w_hot_cnt == 4'd1);
      w_same = (r_s_seg == r_p_seg) && (r_s_an == r_p_an);
      w_inc  = r_count + 8'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_count <= '0;
         r_s_seg <= 7'h7F;
         r_p_seg <= 7'h7F;
         r_s_an  <= '1;
         r_p_an  <= '1;
      end else begin
         r_state <= w_state_d;
         r_count <= w_count_d;
         r_s_seg <= io_bus.seg_n;
         r_p_seg <= r_s_seg;
         r_s_an  <= io_bus.an_n;
         r_p_an  <= r_s_an;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_count_d = r_count;
      w_cap     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_act) begin
               w_state_d = StDwell;
               w_count_d = 8'd1;
            end
         end
         StDwell: begin
            if (!w_act) begin
               w_state_d = StIdle;
               w_count_d = 8'd0;
            end else if (!w_same) begin
               w_count_d = 8'd1;
            end else begin
               w_count_d = w_inc;
               if (w_inc == STABLE_CYCLES[7:0]) begin
                  w_cap     = 1'b1;
                  w_state_d = StHeld;
               end
            end
         end
         StHeld: begin
            if (!w_act) begin
               w_state_d = StIdle;
               w_count_d = 8'd0;
            end else if (!w_same) begin
               w_state_d = StDwell;
               w_count_d = 8'd1;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_count_d = 8'd0;
         end
      endcase
   end

   always_comb begin
      w_code   = f_decode(r_s_seg);
      w_bad    = (w_code == 4'hE);
      w_new    = '0;
      w_bcd_d  = r_bcd;
      w_dv_d   = r_dv;
      w_mask_d = r_mask;
      w_err_d  = r_err;
      w_fv_d   = 1'b0;
      w_fe_d   = 1'b0;
      w_de_d   = 1'b0;
      if (w_cap) begin
         w_new[w_idx]                 = 1'b1;
         w_bcd_d[{w_idx, 2'b00} +: 4] = w_code;
         w_dv_d[w_idx]                = (w_code <= 4'd9);
         w_de_d                       = w_bad;
         // Frame closes on the capture that fills the last missing position.
         if ((r_mask | w_new) == '1) begin
            w_fv_d   = 1'b1;
            w_fe_d   = r_err | w_bad;
            w_mask_d = '0;
            w_err_d  = 1'b0;
         end else begin
            w_mask_d = r_mask | w_new;
            w_err_d  = r_err | w_bad;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bcd  <= '1;
         r_dv   <= '0;
         r_mask <= '0;
         r_err  <= 1'b0;
         r_fv   <= 1'b0;
         r_fe   <= 1'b0;
         r_de   <= 1'b0;
      end else begin
         r_bcd  <= w_bcd_d;
         r_dv   <= w_dv_d;
         r_mask <= w_mask_d;
         r_err  <= w_err_d;
         r_fv   <= w_fv_d;
         r_fe   <= w_fe_d;
         r_de   <= w_de_d;
      end
   end

   assign io_bus.bcd_out     = r_bcd;
   assign io_bus.digit_valid = r_dv;
   assign io_bus.frame_valid = r_fv;
   assign io_bus.frame_err   = r_fe;
   assign io_bus.decode_err  = r_de;
endmodule
